irq_controller: RTL and testbench

//   Generates the INT request the processor top consumes. Today the bench drives INT by hand.

---
 rtl/irq_controller_pkg.sv | 27 ++
 rtl/irq_prio_enc.sv | 29 ++
 rtl/irq_controller.sv | 114 +++++++++++
 tb/tb_irq_controller.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/irq_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module   : irq_controller_pkg
// Purpose  : Shared types and constants for the interrupt controller
//            (FSM state encoding, default vector base, vector stride).
// Revision : 1.0  initial release
// ============================================================================
package irq_controller_pkg;

  // Controller states; encoding is fixed so debug readback stays stable
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } irq_state_t;

  localparam logic [31:0] c_vec_base_default = 32'h0000_0100;
  localparam logic [31:0] c_vec_stride       = 32'd4;

  // Service-routine address for a given line index
  function automatic logic [31:0] vec_addr(input logic [31:0] base,
                                           input logic [31:0] idx);
    return base + (idx * c_vec_stride);
  endfunction

endpackage
`default_nettype wire

// File: rtl/irq_prio_enc.sv
`default_nettype none
// ============================================================================
// Module   : irq_prio_enc
// Purpose  : Fixed-priority encoder, lowest set index wins.
//            Purely combinational.
// Revision : 1.0  initial release
// ============================================================================
module irq_prio_enc #(
  parameter int NUM_IRQ = 8,
  parameter int ID_W    = 3
) (
  input  logic [NUM_IRQ-1:0] eligible,
  output logic               valid,
  output logic [ID_W-1:0]    id
);

  // Scan from the top down so the lowest eligible index is written last
  always_comb begin
    valid = |eligible;
    id    = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        id = ID_W'(i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/irq_controller.sv
`default_nettype none
// ============================================================================
// Module   : irq_controller
// Purpose  : Edge-latching, maskable, fixed-priority interrupt controller.
//            Raises INT, returns the vector on ack and blocks further
//            requests until end-of-interrupt.
// Revision : 1.0  initial release
// ============================================================================
module irq_controller
  import irq_controller_pkg::*;
#(
  parameter int          NUM_IRQ  = 8,
  parameter int          ID_W     = 3,
  parameter logic [31:0] VEC_BASE = c_vec_base_default
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_wdata,
  input  logic               int_ack,
  input  logic               eoi,
  output logic               INT,
  output logic [ID_W-1:0]    int_id,
  output logic [31:0]        int_vector,
  output logic               in_service,
  output logic [NUM_IRQ-1:0] pending
);

  logic [NUM_IRQ-1:0] r_irq_q;
  logic [NUM_IRQ-1:0] r_pending;
  logic [NUM_IRQ-1:0] r_mask;
  irq_state_t         r_state;

  logic [NUM_IRQ-1:0] w_rise;
  logic [NUM_IRQ-1:0] w_eligible;
  logic [NUM_IRQ-1:0] w_clr;
  logic               w_win_valid;
  logic [ID_W-1:0]    w_win_id;
  logic               w_ack_take;

  assign w_rise     = irq_in & ~r_irq_q;
  assign w_eligible = r_pending & ~r_mask;
  // An ack only counts while a request is actually being offered
  assign w_ack_take = (r_state == ST_REQ) && int_ack;
  assign w_clr      = w_ack_take ? (NUM_IRQ'(1) << int_id) : '0;
  assign pending    = r_pending;

  irq_prio_enc #(
    .NUM_IRQ (NUM_IRQ),
    .ID_W    (ID_W)
  ) u_prio_enc (
    .eligible (w_eligible),
    .valid    (w_win_valid),
    .id       (w_win_id)
  );

  // Edge capture, pending and mask; a new rise beats the ack clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_irq_q   <= '0;
      r_pending <= '0;
      r_mask    <= '0;
    end else begin
      r_irq_q   <= irq_in;
      r_pending <= (r_pending & ~w_clr) | w_rise;
      if (mask_we) begin
        r_mask <= mask_wdata;
      end
    end
  end

  // Request/service FSM with registered outputs; the request is frozen in REQ
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      INT        <= 1'b0;
      int_id     <= '0;
      int_vector <= VEC_BASE;
      in_service <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_win_valid) begin
            int_id     <= w_win_id;
            int_vector <= vec_addr(VEC_BASE, 32'(w_win_id));
            INT        <= 1'b1;
            r_state    <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (int_ack) begin
            INT        <= 1'b0;
            in_service <= 1'b1;
            r_state    <= ST_SERVICE;
          end
        end
        ST_SERVICE: begin
          if (eoi) begin
            in_service <= 1'b0;
            r_state    <= ST_IDLE;
          end
        end
        default: begin
          INT        <= 1'b0;
          in_service <= 1'b0;
          r_state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_irq_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_irq_controller
// Purpose  : Directed self-checking bench for irq_controller.
// Revision : 1.0  initial release
// ============================================================================
module tb_irq_controller;

  logic       clk;
  logic       rst;
  logic [7:0] irq_in;
  logic       mask_we;
  logic [7:0] mask_wdata;
  logic       int_ack;
  logic       eoi;
  logic       INT;
  logic [2:0] int_id;
  logic [31:0] int_vector;
  logic       in_service;
  logic [7:0] pending;

  int n_cmp;
  int n_err;

  irq_controller #(
    .NUM_IRQ  (8),
    .ID_W     (3),
    .VEC_BASE (32'h0000_0100)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .irq_in     (irq_in),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .int_ack    (int_ack),
    .eoi        (eoi),
    .INT        (INT),
    .int_id     (int_id),
    .int_vector (int_vector),
    .in_service (in_service),
    .pending    (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle pulse on irq lines (rise seen at the next edge)
  task automatic pulse_irq(input logic [7:0] lines);
    irq_in = lines;
    tick();
    irq_in = 8'h00;
  endtask

  task automatic do_ack();
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
  endtask

  task automatic do_eoi();
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst = 1'b1; irq_in = 8'h00; mask_we = 1'b0; mask_wdata = 8'h00;
    int_ack = 1'b0; eoi = 1'b0;
    tick(); tick();

    // Reset state
    check("rst_int", 32'(INT), 32'd0);
    check("rst_id", 32'(int_id), 32'd0);
    check("rst_vec", int_vector, 32'h100);
    check("rst_insvc", 32'(in_service), 32'd0);
    check("rst_pend", 32'(pending), 32'h00);
    rst = 1'b0;
    tick();

    // 1: single request on line 3
    pulse_irq(8'h08);
    check("t1_pend", 32'(pending), 32'h08);
    check("t1_int_early", 32'(INT), 32'd0);
    tick();
    check("t1_int", 32'(INT), 32'd1);
    check("t1_id", 32'(int_id), 32'd3);
    check("t1_vec", int_vector, 32'h10C);
    do_ack();
    check("t1_ack_int", 32'(INT), 32'd0);
    check("t1_ack_insvc", 32'(in_service), 32'd1);
    check("t1_ack_pend", 32'(pending), 32'h00);
    do_eoi();
    check("t1_eoi_insvc", 32'(in_service), 32'd0);
    tick();
    check("t1_idle_int", 32'(INT), 32'd0);

    // 2: simultaneous rises on 5 and 2
    pulse_irq(8'h24);
    tick();
    check("t2_int", 32'(INT), 32'd1);
    check("t2_id_first", 32'(int_id), 32'd2);
    do_ack();
    check("t2_svc_int", 32'(INT), 32'd0);
    check("t2_svc_pend", 32'(pending), 32'h20);
    do_eoi();
    check("t2_gap_int", 32'(INT), 32'd0);
    tick();
    check("t2_int2", 32'(INT), 32'd1);
    check("t2_id_second", 32'(int_id), 32'd5);
    check("t2_vec_second", int_vector, 32'h114);
    do_ack(); do_eoi();

    // 3: masked line stays pending, fires when unmasked
    mask_we = 1'b1; mask_wdata = 8'h01;
    pulse_irq(8'h01);
    mask_we = 1'b0;
    tick(); tick();
    check("t3_masked_int", 32'(INT), 32'd0);
    check("t3_masked_pend", 32'(pending), 32'h01);
    mask_we = 1'b1; mask_wdata = 8'h00;
    tick();
    mask_we = 1'b0;
    tick();
    check("t3_unmask_int", 32'(INT), 32'd1);
    check("t3_unmask_id", 32'(int_id), 32'd0);
    do_ack(); do_eoi();

    // 4: request frozen in REQ against higher-priority arrival
    pulse_irq(8'h10);
    tick();
    check("t4_id4", 32'(int_id), 32'd4);
    pulse_irq(8'h02);
    tick();
    check("t4_frozen_id", 32'(int_id), 32'd4);
    check("t4_frozen_pend", 32'(pending), 32'h12);
    do_ack();
    check("t4_svc_pend", 32'(pending), 32'h02);
    tick();
    check("t4_svc_noint", 32'(INT), 32'd0);
    do_eoi();
    tick();
    check("t4_next_int", 32'(INT), 32'd1);
    check("t4_next_id", 32'(int_id), 32'd1);
    do_ack(); do_eoi();

    // 5: illegal ack/eoi ignored; rise coinciding with ack stays pending
    do_ack();
    check("t5_idle_ack_int", 32'(INT), 32'd0);
    check("t5_idle_ack_insvc", 32'(in_service), 32'd0);
    pulse_irq(8'h40);
    tick();
    check("t5_req_id", 32'(int_id), 32'd6);
    do_eoi();
    check("t5_req_eoi_int", 32'(INT), 32'd1);
    check("t5_req_eoi_insvc", 32'(in_service), 32'd0);
    irq_in = 8'h40; int_ack = 1'b1;
    tick();
    irq_in = 8'h00; int_ack = 1'b0;
    check("t5_setwins_pend", 32'(pending), 32'h40);
    check("t5_setwins_insvc", 32'(in_service), 32'd1);
    do_eoi();
    tick();
    check("t5_again_int", 32'(INT), 32'd1);
    check("t5_again_id", 32'(int_id), 32'd6);
    // ack and eoi together: ack taken, eoi dropped
    int_ack = 1'b1; eoi = 1'b1;
    tick();
    int_ack = 1'b0; eoi = 1'b0;
    check("t5_both_insvc", 32'(in_service), 32'd1);
    tick();
    check("t5_both_stay", 32'(in_service), 32'd1);
    do_eoi();

    // 6: asynchronous reset in SERVICE and in REQ
    pulse_irq(8'h09);
    tick();
    check("t6_id0", 32'(int_id), 32'd0);
    do_ack();
    check("t6_svc_pend", 32'(pending), 32'h08);
    rst = 1'b1;
    #2;
    check("t6_rst_insvc", 32'(in_service), 32'd0);
    check("t6_rst_pend", 32'(pending), 32'h00);
    rst = 1'b0;
    tick();
    pulse_irq(8'h20);
    tick();
    check("t6_req_int", 32'(INT), 32'd1);
    rst = 1'b1;
    #2;
    check("t6_rst_int", 32'(INT), 32'd0);
    check("t6_rst_id", 32'(int_id), 32'd0);
    rst = 1'b0;
    tick();
    pulse_irq(8'h80);
    tick();
    check("t6_after_int", 32'(INT), 32'd1);
    check("t6_after_id", 32'(int_id), 32'd7);
    check("t6_after_vec", int_vector, 32'h11C);
    do_ack();
    check("t6_after_insvc", 32'(in_service), 32'd1);
    do_eoi();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
